seq_shift_unit: RTL
===================

// Module: seq_shift_unit
// PURPOSE
//  Multi-cycle parametrised barrel-shift unit for the EX-stage ALU. Successor to the single-cycle SLL op.
//  Executes SLL/SRL/SRA (optionally ROL/ROR) by shifting at most STEP bits per cycle, trading latency for area.
//  Valid/ready handshake on input and output lets the EX stage stall on it like any other multi-cycle unit.
// PARAMETERS
//  XLEN  32  operand/result width; power of 2, >= 8
//  STEP  4   max bits shifted per cycle; power of 2, 1..XLEN
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     synchronous reset, active-high
//  in_valid    in   1     request present
//  in_ready    out  1     unit can accept request
//  in_op       in   3     shift_op_t: 000 SLL, 001 SRL, 010 SRA, 100 ROL, 101 ROR
//  in_a        in   XLEN  value to shift
//  in_b        in   XLEN  shift amount source; only b[$clog2(XLEN)-1:0] used
//  out_valid   out  1     result present
//  out_ready   in   1     consumer takes result
//  out_result  out  XLEN  shifted value
//  busy        out  1     state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, out_valid=0, out_result=0, internal regs 0.
//    in_ready=0 while rst high. In-flight op discarded, never produces out_valid.
//  - FSM states IDLE, SHIFT, DONE. Encoding is shift_state_t.
//  - IDLE: in_ready=1. On in_valid&&in_ready, capture op, a, shamt=b[SHW-1:0] (upper bits ignored, RISC-V semantics), sign=a[XLEN-1].
//    Next state is DONE if shamt==0, else SHIFT.
//  - SHIFT: each cycle acc shifted by k=min(rem,STEP), rem-=k. Go to DONE when rem reaches 0.
//    SLL: zero-fill from LSB. SRL: zero-fill from MSB. SRA: fill with captured sign.
//  - DONE: out_valid=1, out_result=acc. Held stable while out_ready=0.
//    On out_ready, go to IDLE and out_valid=0 next cycle. in_ready=0 in DONE, so no same-cycle accept.
//  - Latency: accept at cycle T, out_valid at T+1+ceil(shamt/STEP). Throughput: one op per latency+1 cycles minimum.
//  - in_* ignored unless accepted. Inputs may change freely after the accept edge.
//  - shamt=XLEN-1 is the worst case: XLEN/STEP+1 cycles. No overflow or wrap of rem possible.
//  - Op codes not listed (011, 110, 111): treated as shamt=0, result=a unchanged, latency 1.
// CONFIGURATION
//  SEQ_SHIFT_ROTATE_EN defined:
//    - ROL/ROR supported (Zbb). Vacated bits are filled with bits rotated out. Same latency rule.
//  Undefined:
//    - ops 100/101 are illegal, handled as listed above (result=a, latency 1).
//    - rotate datapath not synthesised.
// STRUCTURE
//  - Package shift_pkg: shift_op_t enum (3 bits, values above), shift_state_t enum, localparam SHW=$clog2(XLEN) helper function.
//  - Sub-module shift_step: combinational, shifts acc by k in 0..STEP for a given op and sign.
//  - Top holds FSM, acc, rem, and handshake logic.
// TESTING
//  (XLEN=32, STEP=4, out_ready=1 unless stated)
//  1. SLL a=1,b=1 -> 0x2, out_valid at T+2. SLL a=3,b=4 -> 48 (0x30), T+2.
//     SLL a=1,b=31 -> 0x80000000, T+9.
//  2. SRA a=0x80000000,b=4 -> 0xF8000000. SRL same -> 0x08000000.
//     SRA a=0x7FFFFFF0,b=4 -> 0x07FFFFFF.
//  3. SLL a=0xA5,b=0 -> 0xA5 at T+1. SLL a=1,b=33 (masked to 1) -> 0x2.
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_result stable, in_ready=0.
//     Release -> IDLE, in_ready=1 next cycle.
//  5. Reset mid-op: SLL b=31, rst at T+3 -> no out_valid. Next op SRL a=0x100,b=8 -> 0x1.
//  6. SEQ_SHIFT_ROTATE_EN: ROR a=0x1,b=1 -> 0x80000000. ROL a=0x80000001,b=4 -> 0x18.
//     Undefined: ROR a=0x1,b=1 -> 0x1, latency 1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit: op codes, FSM state encoding and small helpers.
// Rotate support is selected by the SEQ_SHIFT_ROTATE_EN macro in the RTL that imports this package.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    localparam int XLEN_DEFAULT = 32;

    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

    localparam int SHW = shamt_width(XLEN_DEFAULT);

    // Unlisted codes (and rotates when they are not built) pass the operand through unchanged.
    function automatic logic op_legal(input logic [2:0] op, input logic rot_en);
        case (op)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return rot_en;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts acc_i by k_i (0..STEP) for the given op and captured sign.
// Rotate paths exist only when SEQ_SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SW   = $clog2(XLEN)
) (
    input  shift_op_t         op_i,
    input  logic              sign_i,
    input  logic [XLEN-1:0]   acc_i,
    input  logic [SW-1:0]     k_i,
    output logic [XLEN-1:0]   res_o
);

    logic [XLEN-1:0] ones;
    assign ones = '1;

    always_comb begin
        res_o = acc_i;
        case (op_i)
            OP_SLL: res_o = acc_i << k_i;
            OP_SRL: res_o = acc_i >> k_i;
            // Vacated MSBs take the sign captured at accept, not the current acc MSB.
            OP_SRA: res_o = (acc_i >> k_i) | (sign_i ? ~(ones >> k_i) : '0);
`ifdef SEQ_SHIFT_ROTATE_EN
            OP_ROL: res_o = (acc_i << k_i) | (acc_i >> (XLEN - int'(k_i)));
            OP_ROR: res_o = (acc_i >> k_i) | (acc_i << (XLEN - int'(k_i)));
`endif
            default: res_o = acc_i;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: shifts at most STEP bits per cycle, valid/ready on both sides.
// Define SEQ_SHIFT_ROTATE_EN to build ROL/ROR; otherwise those codes pass the operand through.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              busy
);

    localparam int SW = shamt_width(XLEN);
`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    shift_state_t    state_q;
    shift_op_t       op_q;
    logic            sign_q;
    logic            out_valid_q;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SW-1:0]   rem_q, k_d;
    logic [SW-1:0]   shamt_in;
    logic            unused_b;

    assign shamt_in = in_b[SW-1:0];
    assign unused_b = ^in_b[XLEN-1:SW];

    // STEP may equal XLEN, but rem never exceeds XLEN-1, so k always fits in SW bits.
    assign k_d = (int'(rem_q) > STEP) ? SW'(STEP) : rem_q;

    shift_step #(.XLEN(XLEN), .SW(SW)) u_step (
        .op_i   (op_q),
        .sign_i (sign_q),
        .acc_i  (acc_q),
        .k_i    (k_d),
        .res_o  (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SLL;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            rem_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= shift_op_t'(in_op);
                        acc_q  <= in_a;
                        sign_q <= in_a[XLEN-1];
                        if (shamt_in == '0 || !op_legal(in_op, ROT_EN)) begin
                            rem_q       <= '0;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            rem_q   <= shamt_in;
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_q - k_d;
                    if (rem_q == k_d) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign out_valid  = out_valid_q;
    assign out_result = acc_q;
    assign busy       = (state_q != S_IDLE);

endmodule
